// File: rtl/qs_srt_mstack.sv
// qs_srt_mstack: M independent LIFO stacks of depth N sharing one single-port SRAM,
// with PUSH/POP/PEEK/CLR and a registered, context-tagged head port.
module qs_srt_mstack #(
    parameter int M = 4,
    parameter int N = 16,
    parameter int W = 32,
    localparam int CW = (M > 1) ? $clog2(M) : 1,
    localparam int PW = $clog2(N),
    localparam int AW = (M > 1) ? CW + PW : PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_vld_r,
    input  logic [1:0]    cmd_op_r,
    input  logic [CW-1:0] cmd_ctx_r,
    input  logic [W-1:0]  cmd_push_dat_r,
    output logic          cmd_err_w,
    output logic [W-1:0]  head_r,
    output logic [CW-1:0] head_ctx_r,
    output logic          head_vld_r,
    output logic [M-1:0]  empty_r,
    output logic [M-1:0]  full_r
);
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_PEEK, OP_CLR} op_e;

    logic [PW-1:0]    r_ptr [M];
    logic [W-1:0]     r_mem [M*N];
    logic [W-1:0]     r_dout;
    logic             r_pend;
    logic [CW-1:0]    r_pctx;

    logic [CW-1:0]    w_c;
    logic [PW-1:0]    w_ptr;
    logic [PW-1:0]    w_nptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_peek;
    logic             w_clr;
    logic             w_wr;
    logic             w_rd;
    logic [CW+PW-1:0] w_ext_addr;
    logic [AW-1:0]    w_addr;

    assign w_c        = (M > 1) ? cmd_ctx_r : '0;
    assign w_ptr      = r_ptr[w_c];
    assign w_empty    = empty_r[w_c];
    assign w_full     = full_r[w_c];
    assign w_push     = cmd_vld_r && cmd_op_r == OP_PUSH;
    assign w_pop      = cmd_vld_r && cmd_op_r == OP_POP;
    assign w_peek     = cmd_vld_r && cmd_op_r == OP_PEEK;
    assign w_clr      = cmd_vld_r && cmd_op_r == OP_CLR;
    assign w_wr       = w_push && !w_full;
    assign w_rd       = (w_pop || w_peek) && !w_empty;
    assign cmd_err_w  = (w_push && w_full) || ((w_pop || w_peek) && w_empty);
    // An empty stack keeps ptr at 0, so the first push lands on slot 0.
    assign w_nptr     = w_empty ? w_ptr : w_ptr + PW'(1);
    assign w_ext_addr = {w_c, w_wr ? w_nptr : w_ptr};
    assign w_addr     = w_ext_addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_addr] <= cmd_push_dat_r;
        if (w_rd) r_dout <= r_mem[w_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '{default: '0};
            empty_r    <= '1;
            full_r     <= '0;
            r_pend     <= 1'b0;
            r_pctx     <= '0;
            head_r     <= '0;
            head_ctx_r <= '0;
            head_vld_r <= 1'b0;
        end else begin
            r_pend     <= w_rd;
            head_vld_r <= r_pend;
            if (w_rd) r_pctx <= w_c;
            if (r_pend) begin
                head_r     <= r_dout;
                head_ctx_r <= r_pctx;
            end
            if (w_wr) begin
                r_ptr[w_c]   <= w_nptr;
                empty_r[w_c] <= 1'b0;
                full_r[w_c]  <= w_nptr == PW'(N - 1);
            end else if (w_rd && w_pop) begin
                r_ptr[w_c]   <= (w_ptr == '0) ? w_ptr : w_ptr - PW'(1);
                empty_r[w_c] <= w_ptr == '0;
                full_r[w_c]  <= 1'b0;
            end else if (w_clr) begin
                r_ptr[w_c]   <= '0;
                empty_r[w_c] <= 1'b1;
                full_r[w_c]  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/qs_srt_mstack.md
# qs_srt_mstack

Multi-context LIFO stack for the sort datapath. It holds M independent stacks of depth N in one shared single-port SRAM of M*N words, so the partition engine can keep one pending-range stack per sort context without replicating memories. It adds three things to the single-context stack: a context select, a non-destructive PEEK, and a per-context CLR. Read data returns through a registered head port tagged with the originating context.

## Interface
- M, 4: number of independent stacks (contexts); power of two, >= 1.
- N, 16: depth of each stack; power of two, >= 2.
- W, 32: word width.
- Derived: CW = max(1, $clog2(M)); PW = $clog2(N); SRAM address = {ctx, ptr}, width CW+PW (ctx bits dropped when M == 1).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cmd_vld_r  in  1  command valid; one command per cycle, no backpressure.
- cmd_op_r  in  2  0=PUSH, 1=POP, 2=PEEK, 3=CLR.
- cmd_ctx_r  in  CW  target context.
- cmd_push_dat_r  in  W  PUSH data.
- cmd_err_w  out  1  combinational; command rejected this cycle.
- head_r  out  W  returned word from POP/PEEK.
- head_ctx_r  out  CW  context of head_r.
- head_vld_r  out  1  one-cycle pulse, head_r/head_ctx_r valid.
- empty_r  out  M  per-context empty flag, registered.
- full_r  out  M  per-context full flag, registered.

## Operation
- Per-context state: ptr[c] (PW bits, index of top entry when non-empty), empty_r[c], full_r[c]. Reset: ptr=0, empty_r='1, full_r='0, head_vld_r=0, head_r=0, head_ctx_r=0, internal read-pending flag=0.
- Each cycle, at most one context is updated, the one selected by cmd_ctx_r. All other contexts hold.
- PUSH, !full: if empty, ptr holds (0), else ptr+1. Write SRAM at {ctx, new ptr}. empty<=0. full<=(new ptr == N-1).
- PUSH, full: cmd_err_w=1. No SRAM access, no state change.
- POP, !empty: read SRAM at {ctx, ptr}. If ptr==0, empty<=1 and ptr holds; else ptr-1. full<=0.
- PEEK, !empty: read SRAM at {ctx, ptr}. Pointer and flags unchanged.
- POP/PEEK, empty: cmd_err_w=1. No read, no head_vld_r.
- CLR: ptr<=0, empty<=1, full<=0 for ctx. Never errors. No SRAM access. CLR of an empty context is legal and a no-op.
- cmd_err_w is 0 whenever cmd_vld_r=0.
- The pipeline is an implicit two-state read FSM (IDLE, RD_PEND) held in one flag plus a CW-bit context register. A successful POP/PEEK sets RD_PEND for one cycle. In RD_PEND, head_r<=SRAM dout, head_ctx_r<=latched ctx, head_vld_r<=1. In all other cycles head_vld_r<=0 and head_r/head_ctx_r hold.
- Back-to-back reads pipeline fully; both pulses are delivered in order.

## Timing
- PUSH write commits at the end of the command cycle. Flags update at the same edge, so empty_r/full_r reflect the command from the next cycle.
- POP/PEEK in cycle t: SRAM dout valid in t+1, head_vld_r high in t+2 only. Latency is 2; throughput is 1 per cycle.
- PUSH in t followed by POP/PEEK of the same ctx in t+1 returns the pushed word; the single-port SRAM sees write then read on consecutive cycles.
- A CLR or PUSH issued in t+1 to a context with a read pending from t does not cancel it. The head still delivers the word read at t.
- Reset asserted mid-operation: all state returns to reset values asynchronously and any pending head is discarded. SRAM contents are don't-care after reset, and no output exposes them until written.
- Boundaries: full at N entries; no wrap-around. An illegal op leaves the state bit-identical.

## Test plan
- Fill/drain, M=4, N=16, ctx=2: push 0x100..0x10F. full_r[2]=1 after the 16th push and the 17th push errors. Then 16 POPs return 0x10F..0x100 at 2-cycle latency, empty_r[2]=1 after the last, and the 17th POP errors with no head_vld_r.
- Context isolation: push 0xA to ctx0 and 0xB to ctx3, then POP ctx0 -> head_r=0xA, head_ctx_r=0. POP ctx3 -> 0xB, head_ctx_r=3. Other flags unchanged throughout.
- PEEK: push 0x55 to ctx1, PEEK ctx1 twice -> two pulses with head_r=0x55 each, empty_r[1]=0. POP -> 0x55, empty_r[1]=1.
- CLR: push 3 words to ctx1, CLR ctx1 -> empty_r[1]=1 next cycle. A following POP errors. A push of 0x77 then POP returns 0x77.
- Back-to-back: push 1,2,3 to ctx0, then POP in three consecutive cycles -> head_vld_r high for 3 consecutive cycles with 3,2,1. A POP followed next cycle by CLR of the same ctx still delivers its word.
- Reset mid-read: POP in t, assert rst in t+1 -> head_vld_r stays 0 and all empty_r=1. A subsequent POP errors.
